// File: rtl/onfi_cmd_responder_if.sv
// Host-to-device ONFI command/address bus plus the decoded reports the NAND model consumes.
// master = host side, slave = device-side responder.
interface onfi_cmd_responder_if;
  logic        onfi_cen;
  logic        onfi_cle;
  logic        onfi_ale;
  logic        onfi_wen;
  logic [31:0] onfi_dq_i;
  logic        onfi_dq_en;
  logic        onfi_rbn;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        addr_valid;
  logic [39:0] addr_data;
  logic [2:0]  addr_count;
  logic        reset_done;
  logic        proto_err;
  logic [7:0]  status_byte;

  modport master (
    output onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dq_i, onfi_dq_en,
    input  onfi_rbn, cmd_valid, cmd_code, addr_valid, addr_data, addr_count,
           reset_done, proto_err, status_byte
  );

  modport slave (
    input  onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dq_i, onfi_dq_en,
    output onfi_rbn, cmd_valid, cmd_code, addr_valid, addr_data, addr_count,
           reset_done, proto_err, status_byte
  );
endinterface

// File: rtl/onfi_cmd_responder.sv
// ONFI device-side command/address latch decoder with RESET busy window on R/B#.
// Outputs registered, one cycle after the sampling edge; no backpressure, every edge is consumed.
module onfi_cmd_responder #(
  parameter int RST_BUSY_CYCLES  = 16,
  parameter int READ_ADDR_CYCLES = 5
) (
  input logic                  onfi_clk,
  input logic                  onfi_rstn,
  onfi_cmd_responder_if.slave  bus
);
  localparam int CW = $clog2(RST_BUSY_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RST_BUSY_CYCLES);
  localparam logic [2:0]    RD_CYC   = 3'(READ_ADDR_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    exp_q, exp_d;
  logic [2:0]    addr_count_q, addr_count_d;
  logic [39:0]   addr_data_q, addr_data_d;
  logic [7:0]    cmd_code_q, cmd_code_d;
  logic          rbn_q, rbn_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          addr_valid_q, addr_valid_d;
  logic          reset_done_q, reset_done_d;
  logic          proto_err_q, proto_err_d;
  logic          do_cmd;

  logic       latch, cmd_lat, adr_lat, both_lat;
  logic [7:0] dq_byte;
  logic       unused_dq;

  assign latch     = !bus.onfi_cen && bus.onfi_wen && bus.onfi_dq_en;
  assign cmd_lat   = latch && bus.onfi_cle && !bus.onfi_ale;
  assign adr_lat   = latch && !bus.onfi_cle && bus.onfi_ale;
  assign both_lat  = latch && bus.onfi_cle && bus.onfi_ale;
  assign dq_byte   = bus.onfi_dq_i[7:0];
  assign unused_dq = ^bus.onfi_dq_i[31:8];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    exp_d        = exp_q;
    addr_count_d = addr_count_q;
    addr_data_d  = addr_data_q;
    cmd_code_d   = cmd_code_q;
    rbn_d        = rbn_q;
    cmd_valid_d  = 1'b0;
    addr_valid_d = 1'b0;
    reset_done_d = 1'b0;
    proto_err_d  = 1'b0;
    do_cmd       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_lat)      do_cmd      = 1'b1;
        else if (adr_lat) proto_err_d = 1'b1;
      end
      S_ADDR: begin
        if (bus.onfi_cen) begin
          proto_err_d = 1'b1;
          state_d     = S_IDLE;
        end else if (cmd_lat) begin
          // Abort the phase, then handle the command as if from IDLE.
          proto_err_d = 1'b1;
          do_cmd      = 1'b1;
        end else if (adr_lat) begin
          for (int i = 0; i < 5; i++) begin
            if (addr_count_q == 3'(i)) addr_data_d[8*i +: 8] = dq_byte;
          end
          addr_count_d = addr_count_q + 3'd1;
          if (addr_count_q + 3'd1 == exp_q) begin
            addr_valid_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rbn_d        = 1'b1;
          reset_done_d = 1'b1;
          state_d      = S_IDLE;
        end
        if (cmd_lat) begin
          if (dq_byte == 8'hFF) begin
            // A repeated RESET restarts the window, overriding expiry.
            cmd_valid_d  = 1'b1;
            cmd_code_d   = dq_byte;
            cnt_d        = CNT_LOAD;
            rbn_d        = 1'b0;
            reset_done_d = 1'b0;
            state_d      = S_BUSY;
          end else if (dq_byte == 8'h70) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = dq_byte;
          end else begin
            proto_err_d = 1'b1;
          end
        end else if (adr_lat) begin
          proto_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (both_lat) proto_err_d = 1'b1;

    if (do_cmd) begin
      cmd_code_d  = dq_byte;
      cmd_valid_d = 1'b1;
      case (dq_byte)
        8'hFF: begin
          state_d = S_BUSY;
          rbn_d   = 1'b0;
          cnt_d   = CNT_LOAD;
        end
        8'h90, 8'h00: begin
          state_d      = S_ADDR;
          exp_d        = (dq_byte == 8'h90) ? 3'd1 : RD_CYC;
          addr_count_d = '0;
          addr_data_d  = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge onfi_clk or negedge onfi_rstn) begin
    if (!onfi_rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      exp_q        <= '0;
      addr_count_q <= '0;
      addr_data_q  <= '0;
      cmd_code_q   <= '0;
      rbn_q        <= 1'b1;
      cmd_valid_q  <= 1'b0;
      addr_valid_q <= 1'b0;
      reset_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      exp_q        <= exp_d;
      addr_count_q <= addr_count_d;
      addr_data_q  <= addr_data_d;
      cmd_code_q   <= cmd_code_d;
      rbn_q        <= rbn_d;
      cmd_valid_q  <= cmd_valid_d;
      addr_valid_q <= addr_valid_d;
      reset_done_q <= reset_done_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign bus.onfi_rbn    = rbn_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_code    = cmd_code_q;
  assign bus.addr_valid  = addr_valid_q;
  assign bus.addr_data   = addr_data_q;
  assign bus.addr_count  = addr_count_q;
  assign bus.reset_done  = reset_done_q;
  assign bus.proto_err   = proto_err_q;
  assign bus.status_byte = {1'b1, rbn_q, rbn_q, 5'b0};
endmodule

// File: tb/tb_onfi_cmd_responder.sv
// Directed bench for onfi_cmd_responder: inputs change and outputs are sampled on the falling edge.
module tb_onfi_cmd_responder;
  logic clk;
  logic rstn;
  int   n_assert;
  int   n_fail;
  int   lows;
  logic rd_seen;

  onfi_cmd_responder_if bus ();

  onfi_cmd_responder #(.RST_BUSY_CYCLES(16), .READ_ADDR_CYCLES(5)) dut (
    .onfi_clk  (clk),
    .onfi_rstn (rstn),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic cen, input logic cle, input logic ale,
                      input logic wen, input logic en, input logic [31:0] dq);
    bus.onfi_cen   = cen;
    bus.onfi_cle   = cle;
    bus.onfi_ale   = ale;
    bus.onfi_wen   = wen;
    bus.onfi_dq_en = en;
    bus.onfi_dq_i  = dq;
    @(negedge clk);
  endtask

  task automatic idle();             tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); endtask
  task automatic cmd(input logic [7:0] b); tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, {24'hA5C3E1, b}); endtask
  task automatic adr(input logic [7:0] b); tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, {24'h5A3C1E, b}); endtask

  // Ticks idle until R/B# rises (bounded), counting the low cycles seen.
  task automatic wait_ready(inout int cnt);
    for (int i = 0; i < 60; i++) begin
      idle();
      if (bus.onfi_rbn === 1'b1) break;
      cnt++;
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    bus.onfi_cen = 1'b1; bus.onfi_cle = 1'b0; bus.onfi_ale = 1'b0;
    bus.onfi_wen = 1'b1; bus.onfi_dq_en = 1'b0; bus.onfi_dq_i = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rbn", bus.onfi_rbn, 1);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_addr_valid", bus.addr_valid, 0);
    chk("rst_reset_done", bus.reset_done, 0);
    chk("rst_proto_err", bus.proto_err, 0);
    chk("rst_cmd_code", bus.cmd_code, 0);
    chk("rst_addr_data", bus.addr_data, 0);
    chk("rst_addr_count", bus.addr_count, 0);
    chk("rst_status", bus.status_byte, 8'hE0);
    rstn = 1'b1;
    idle();

    // Unqualified FFh cycles must be ignored.
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFF);
    chk("qual_cen_cmd_valid", bus.cmd_valid, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFF);
    chk("qual_dqen_cmd_valid", bus.cmd_valid, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFF);
    chk("qual_wen_cmd_valid", bus.cmd_valid, 0);
    chk("qual_rbn", bus.onfi_rbn, 1);

    // RESET: 16 busy cycles then a single reset_done pulse.
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h000000FF);
    chk("rst_cmd_pulse", bus.cmd_valid, 1);
    chk("rst_cmd_code_ff", bus.cmd_code, 8'hFF);
    chk("busy_rbn_low", bus.onfi_rbn, 0);
    chk("busy_status", bus.status_byte, 8'h80);
    lows = 1;
    idle();
    chk("rst_cmd_pulse_end", bus.cmd_valid, 0);
    lows++;
    wait_ready(lows);
    chk("busy_len_16", lows, 16);
    chk("reset_done_pulse", bus.reset_done, 1);
    chk("ready_status", bus.status_byte, 8'hE0);
    idle();
    chk("reset_done_end", bus.reset_done, 0);

    // READ ID
    cmd(8'h90);
    chk("rid_cmd_valid", bus.cmd_valid, 1);
    chk("rid_cmd_code", bus.cmd_code, 8'h90);
    adr(8'h00);
    chk("rid_addr_valid", bus.addr_valid, 1);
    chk("rid_addr_count", bus.addr_count, 1);
    chk("rid_addr_data", bus.addr_data, 0);
    idle();
    chk("rid_addr_valid_end", bus.addr_valid, 0);

    // READ with five back-to-back address cycles
    cmd(8'h00);
    chk("rd_cmd_code", bus.cmd_code, 8'h00);
    adr(8'h01); adr(8'h02); adr(8'h03); adr(8'h04);
    chk("rd_no_early_valid", bus.addr_valid, 0);
    chk("rd_count_4", bus.addr_count, 4);
    adr(8'h05);
    chk("rd_addr_valid", bus.addr_valid, 1);
    chk("rd_addr_data", bus.addr_data, 40'h0504030201);
    chk("rd_addr_count", bus.addr_count, 5);
    idle();
    chk("rd_addr_valid_end", bus.addr_valid, 0);
    chk("rd_addr_held", bus.addr_data, 40'h0504030201);

    // CLE and ALE together
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h90);
    chk("both_proto_err", bus.proto_err, 1);
    chk("both_no_cmd", bus.cmd_valid, 0);
    chk("both_code_held", bus.cmd_code, 8'h00);
    idle();
    chk("both_err_end", bus.proto_err, 0);

    // Address latch while IDLE
    adr(8'h33);
    chk("idle_adr_err", bus.proto_err, 1);

    // Command during an address phase aborts it
    cmd(8'h00);
    chk("addr_cleared_data", bus.addr_data, 0);
    chk("addr_cleared_count", bus.addr_count, 0);
    adr(8'hAA); adr(8'hBB);
    cmd(8'h70);
    chk("abort_proto_err", bus.proto_err, 1);
    chk("abort_cmd_valid", bus.cmd_valid, 1);
    chk("abort_cmd_code", bus.cmd_code, 8'h70);
    chk("abort_no_addr_valid", bus.addr_valid, 0);
    adr(8'hCC);
    chk("abort_now_idle", bus.proto_err, 1);
    chk("abort_idle_no_av", bus.addr_valid, 0);

    // CE# deasserted mid-phase
    cmd(8'h90);
    idle();
    chk("cen_high_err", bus.proto_err, 1);
    adr(8'h11);
    chk("cen_then_idle", bus.addr_valid, 0);

    // Second FFh latched at edge 10 restarts the window: 10+16 low cycles.
    cmd(8'hFF);
    lows = 1;
    for (int i = 0; i < 9; i++) begin
      idle();
      if (bus.onfi_rbn === 1'b0) lows++;
    end
    chk("busy_pre_restart", lows, 10);
    cmd(8'hFF);
    chk("restart_cmd_valid", bus.cmd_valid, 1);
    lows++;
    wait_ready(lows);
    chk("busy_len_26", lows, 26);
    chk("restart_reset_done", bus.reset_done, 1);

    // Commands inside BUSY, then reset at busy cycle 5
    cmd(8'hFF);
    cmd(8'h70);
    chk("busy_70_valid", bus.cmd_valid, 1);
    chk("busy_70_code", bus.cmd_code, 8'h70);
    chk("busy_70_still_busy", bus.onfi_rbn, 0);
    cmd(8'h90);
    chk("busy_90_err", bus.proto_err, 1);
    chk("busy_90_no_valid", bus.cmd_valid, 0);
    chk("busy_90_code_held", bus.cmd_code, 8'h70);
    idle();
    idle();
    rstn = 1'b0;
    #1;
    chk("midrst_rbn", bus.onfi_rbn, 1);
    chk("midrst_code", bus.cmd_code, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    rd_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (bus.reset_done === 1'b1 || bus.onfi_rbn === 1'b0) rd_seen = 1'b1;
    end
    chk("midrst_no_done", rd_seen, 0);
    cmd(8'hFF);
    chk("post_rst_busy", bus.onfi_rbn, 0);
    lows = 1;
    wait_ready(lows);
    chk("post_rst_len", lows, 16);
    chk("post_rst_done", bus.reset_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
